tero_avg: RTL and testbench

Response-side counterpart of the TERO PUF core controller. It accepts each oscillation count that the controller flags with `add_response`, and accumulates `REPETITIONS` counts per loop. It then reduces the average to one response bit and stores that bit at the loop's index. It throttles the controller through `next_enable` and presents the full `NUM_LOOPS`-bit response once the controller reports `done`.

---
 rtl/tero_pkg.sv | 31 +++
 rtl/tero_avg.sv | 146 ++++++++++++++
 tb/tb_tero_avg.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/tero_pkg.sv
// Shared definitions for the TERO PUF controller and its response averager.
package tero_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READY,
    ACCUM,
    STORE,
    FINISHED
  } tero_avg_state_t;

  // Smallest r with 2**r >= reps; exact log2 when reps is a power of two.
  function automatic int LOG2_REP(input int reps);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < reps) r = i + 1;
    end
    return r;
  endfunction

  // Width of a loop index port; wide enough to also carry out-of-range values.
  function automatic int loop_sel_bits(input int loops);
    return $clog2(loops - 1) + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 1) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/tero_avg.sv
// Averages REPETITIONS oscillation counts per TERO loop, reduces each average to
// one response bit and presents the full response once the controller is done.
module tero_avg
  import tero_pkg::*;
#(
  parameter int NUM_LOOPS   = 4,
  parameter int REPETITIONS = 1,
  parameter int COUNT_BITS  = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [loop_sel_bits(NUM_LOOPS)-1:0]  select,
  input  logic                                 add_response,
  input  logic [COUNT_BITS-1:0]                loop_count,
  input  logic                                 done,
  output logic                                 next_enable,
  output logic [NUM_LOOPS-1:0]                 response,
  output logic                                 response_valid,
  output logic                                 protocol_error
);

  localparam int SEL_W = loop_sel_bits(NUM_LOOPS);
  localparam int LOG2  = LOG2_REP(REPETITIONS);
  localparam int SUM_W = COUNT_BITS + LOG2;
  localparam int REP_W = $clog2(REPETITIONS + 1);

  generate
    if (!is_pow2(REPETITIONS)) begin : g_rep_check
      $error("tero_avg: REPETITIONS must be a power of two");
    end
  endgenerate

  tero_avg_state_t      state, state_next;
  logic [SUM_W-1:0]     sum, sum_next;
  logic [REP_W-1:0]     rep, rep_next;
  logic [SEL_W-1:0]     cur_sel, cur_sel_next;
  logic [NUM_LOOPS-1:0] response_next;
  logic                 error_next;
  logic                 pending_done, pending_next;
  logic                 sel_in_range;
  logic                 enable_next;

  assign sel_in_range = int'(select) < NUM_LOOPS;
  assign enable_next  = (state_next == IDLE) || (state_next == READY) ||
                        (state_next == FINISHED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      sum            <= '0;
      rep            <= '0;
      cur_sel        <= '0;
      response       <= '0;
      protocol_error <= 1'b0;
      pending_done   <= 1'b0;
      next_enable    <= 1'b1;
      response_valid <= 1'b0;
    end else begin
      state          <= state_next;
      sum            <= sum_next;
      rep            <= rep_next;
      cur_sel        <= cur_sel_next;
      response       <= response_next;
      protocol_error <= error_next;
      pending_done   <= pending_next;
      next_enable    <= enable_next;
      response_valid <= (state_next == FINISHED);
    end
  end

  // A done seen while busy is remembered and honoured on the next return to READY.
  always_comb begin
    state_next    = state;
    sum_next      = sum;
    rep_next      = rep;
    cur_sel_next  = cur_sel;
    response_next = response;
    error_next    = protocol_error;
    pending_next  = pending_done;

    if (start) begin
      state_next    = READY;
      sum_next      = '0;
      rep_next      = '0;
      cur_sel_next  = '0;
      response_next = '0;
      error_next    = 1'b0;
      pending_next  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (add_response) error_next = 1'b1;
        end
        READY: begin
          if (add_response) begin
            if (done) pending_next = 1'b1;
            if (!sel_in_range) begin
              error_next = 1'b1;
            end else if ((rep != '0) && (select != cur_sel)) begin
              error_next   = 1'b1;
              sum_next     = SUM_W'(loop_count);
              rep_next     = REP_W'(1);
              cur_sel_next = select;
              state_next   = ACCUM;
            end else begin
              if (rep == '0) cur_sel_next = select;
              sum_next   = sum + SUM_W'(loop_count);
              rep_next   = rep + REP_W'(1);
              state_next = ACCUM;
            end
          end else if (done || pending_done) begin
            state_next   = FINISHED;
            pending_next = 1'b0;
            if (rep != '0) begin
              error_next = 1'b1;
              sum_next   = '0;
              rep_next   = '0;
            end
          end
        end
        ACCUM: begin
          if (add_response) error_next = 1'b1;
          if (done) pending_next = 1'b1;
          state_next = (rep == REP_W'(REPETITIONS)) ? STORE : READY;
        end
        STORE: begin
          if (add_response) error_next = 1'b1;
          if (done) pending_next = 1'b1;
          // Bit LOG2 of the sum is bit 0 of the average sum >> LOG2.
          for (int i = 0; i < NUM_LOOPS; i++) begin
            if (int'(cur_sel) == i) response_next[i] = sum[LOG2];
          end
          sum_next   = '0;
          rep_next   = '0;
          state_next = READY;
        end
        FINISHED: begin
          if (add_response) error_next = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tero_avg.sv
// Directed bench for tero_avg: one instance averaging single counts, one averaging four.
module tb_tero_avg;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] select;
  logic       add_response;
  logic [7:0] loop_count;
  logic       done;

  logic       ne1, valid1, err1;
  logic [3:0] resp1;
  logic       ne4, valid4, err4;
  logic [3:0] resp4;

  int checks;
  int errors;

  tero_avg #(.NUM_LOOPS(4), .REPETITIONS(1), .COUNT_BITS(8)) u_rep1 (
    .clk(clk), .reset(reset), .start(start), .select(select),
    .add_response(add_response), .loop_count(loop_count), .done(done),
    .next_enable(ne1), .response(resp1), .response_valid(valid1),
    .protocol_error(err1)
  );

  tero_avg #(.NUM_LOOPS(4), .REPETITIONS(4), .COUNT_BITS(8)) u_rep4 (
    .clk(clk), .reset(reset), .start(start), .select(select),
    .add_response(add_response), .loop_count(loop_count), .done(done),
    .next_enable(ne4), .response(resp4), .response_valid(valid4),
    .protocol_error(err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Pulses add_response once from a negedge and measures how many sampled
  // cycles next_enable stays low afterwards (bounded).
  task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] cnt,
                               input bit on4, input int exp_low, input string tag);
    int low;
    low = 0;
    select = sel;
    loop_count = cnt;
    add_response = 1'b1;
    @(negedge clk);
    add_response = 1'b0;
    while (low < 6 && !(on4 ? ne4 : ne1)) begin
      low++;
      @(negedge clk);
    end
    checkOutput(tag, low, exp_low);
  endtask

  task automatic startEval();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic doneEval();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    start = 1'b0;
    select = '0;
    add_response = 1'b0;
    loop_count = '0;
    done = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ne", ne4, 1);
    checkOutput("rst_resp", resp4, 0);
    checkOutput("rst_valid", valid4, 0);
    checkOutput("rst_err", err4, 0);
    checkOutput("rst_ne1", ne1, 1);
    reset = 1'b1;
    @(negedge clk);

    // Single-count averaging: odd counts give 1, even give 0.
    startEval();
    applyStimulus(3'd0, 8'd5, 1'b0, 2, "r1_s0_low");
    checkOutput("r1_resp_after_s0", resp1, 4'b0001);
    applyStimulus(3'd1, 8'd6, 1'b0, 2, "r1_s1_low");
    applyStimulus(3'd2, 8'd7, 1'b0, 2, "r1_s2_low");
    applyStimulus(3'd3, 8'd9, 1'b0, 2, "r1_s3_low");
    checkOutput("r1_valid_before_done", valid1, 0);
    doneEval();
    checkOutput("r1_resp", resp1, 4'b1101);
    checkOutput("r1_valid", valid1, 1);
    checkOutput("r1_err", err1, 0);
    checkOutput("r1_ne_fin", ne1, 1);

    // Four-count group on loop 2: sum 46, average 11.
    startEval();
    checkOutput("r4_err_cleared", err4, 0);
    applyStimulus(3'd2, 8'd10, 1'b1, 1, "r4_s0_low");
    applyStimulus(3'd2, 8'd11, 1'b1, 1, "r4_s1_low");
    applyStimulus(3'd2, 8'd12, 1'b1, 1, "r4_s2_low");
    checkOutput("r4_resp_partial", resp4, 4'b0000);
    applyStimulus(3'd2, 8'd13, 1'b1, 2, "r4_s3_low");
    checkOutput("r4_resp", resp4, 4'b0100);
    checkOutput("r4_err", err4, 0);

    // Second pulse while next_enable is low must be dropped.
    startEval();
    select = 3'd1;
    loop_count = 8'd3;
    add_response = 1'b1;
    @(negedge clk);
    loop_count = 8'd100;
    @(negedge clk);
    add_response = 1'b0;
    checkOutput("bb_err", err4, 1);
    checkOutput("bb_ne", ne4, 1);
    applyStimulus(3'd1, 8'd4, 1'b1, 1, "bb_s1_low");
    applyStimulus(3'd1, 8'd4, 1'b1, 1, "bb_s2_low");
    applyStimulus(3'd1, 8'd4, 1'b1, 2, "bb_s3_low");
    checkOutput("bb_resp", resp4, 4'b0010);

    // Select change mid-group restarts the group on the new loop.
    startEval();
    checkOutput("mm_err_cleared", err4, 0);
    applyStimulus(3'd1, 8'd1, 1'b1, 1, "mm_a0_low");
    applyStimulus(3'd1, 8'd1, 1'b1, 1, "mm_a1_low");
    applyStimulus(3'd3, 8'd13, 1'b1, 1, "mm_b0_low");
    checkOutput("mm_err", err4, 1);
    applyStimulus(3'd3, 8'd13, 1'b1, 1, "mm_b1_low");
    applyStimulus(3'd3, 8'd13, 1'b1, 1, "mm_b2_low");
    applyStimulus(3'd3, 8'd13, 1'b1, 2, "mm_b3_low");
    checkOutput("mm_resp", resp4, 4'b1000);

    // Out-of-range select, then asynchronous reset while accumulating.
    startEval();
    applyStimulus(3'd5, 8'd0, 1'b1, 0, "oor_low");
    checkOutput("oor_err", err4, 1);
    select = 3'd0;
    loop_count = 8'd1;
    add_response = 1'b1;
    @(negedge clk);
    add_response = 1'b0;
    checkOutput("accum_ne", ne4, 0);
    reset = 1'b0;
    #1;
    checkOutput("arst_ne", ne4, 1);
    checkOutput("arst_err", err4, 0);
    checkOutput("arst_resp", resp4, 0);
    checkOutput("arst_valid", valid4, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    startEval();
    applyStimulus(3'd0, 8'd5, 1'b1, 1, "post_s0_low");
    applyStimulus(3'd0, 8'd5, 1'b1, 1, "post_s1_low");
    applyStimulus(3'd0, 8'd5, 1'b1, 1, "post_s2_low");
    applyStimulus(3'd0, 8'd6, 1'b1, 2, "post_s3_low");
    doneEval();
    checkOutput("post_resp", resp4, 4'b0001);
    checkOutput("post_valid", valid4, 1);
    checkOutput("post_err", err4, 0);

    // Samples in FINISHED are flagged; start then clears everything.
    applyStimulus(3'd0, 8'd7, 1'b1, 0, "fin_add_low");
    checkOutput("fin_add_err", err4, 1);
    checkOutput("fin_add_resp", resp4, 4'b0001);
    checkOutput("fin_add_valid", valid4, 1);
    startEval();
    checkOutput("restart_valid", valid4, 0);
    checkOutput("restart_resp", resp4, 0);
    checkOutput("restart_err", err4, 0);
    checkOutput("restart_ne", ne4, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
